nl_req_arbiter: RTL and testbench

Arbitrates next-level (L2/memory) requests between the instruction cache and the data cache, and sequences the single shared next-level port. Each cache presents a line address and 2-bit command; the arbiter grants one requester at a time round-robin, issues the request downstream with a valid/ready handshake, then holds the port busy for a fixed occupancy window. It also keeps per-source grant and conflict counters for the statistics module.

---
 rtl/nl_req_arbiter_if.sv | 35 +++
 rtl/nl_req_arbiter.sv | 97 +++++++++
 tb/tb_nl_req_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nl_req_arbiter_if.sv
// Request/response bundle between the two caches, the arbiter and the next-level port.
// The slave modport is the arbiter's view; master is the environment driving it.
interface nl_req_arbiter_if #(
  parameter int ADDR_W = 26
);
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_cmd;
  logic              i_ready;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_cmd;
  logic              d_ready;
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_cmd;
  logic              m_src;
  logic              m_ready;
  logic              done;
  logic [31:0]       grants_i;
  logic [31:0]       grants_d;
  logic [31:0]       conflicts;

  modport slave (
    input  i_valid, i_addr, i_cmd, d_valid, d_addr, d_cmd, m_ready,
    output i_ready, d_ready, m_valid, m_addr, m_cmd, m_src, done,
           grants_i, grants_d, conflicts
  );

  modport master (
    output i_valid, i_addr, i_cmd, d_valid, d_addr, d_cmd, m_ready,
    input  i_ready, d_ready, m_valid, m_addr, m_cmd, m_src, done,
           grants_i, grants_d, conflicts
  );
endinterface

// File: rtl/nl_req_arbiter.sv
// Round-robin I/D arbiter for the shared next-level port; accept->m_valid 1 cycle, busy LAT cycles after m_ready.
// Backpressure: requesters hold until ready; m_ready low stretches ISSUE, no buffering of unaccepted requests.
module nl_req_arbiter #(
  parameter int ADDR_W = 26,
  parameter int LAT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  nl_req_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [7:0] LAT_V = 8'(LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_src;
  logic [ADDR_W-1:0] r_m_addr;
  logic [1:0]        r_m_cmd;
  logic              r_m_src;
  logic [7:0]        r_cnt;
  logic [31:0]       r_grants_i;
  logic [31:0]       r_grants_d;
  logic [31:0]       r_conflicts;

  logic              w_idle;
  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_acc;
  logic              w_fwd;
  logic              w_both;
  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    w_idle  = (r_state == S_IDLE);
    w_both  = bus.i_valid & bus.d_valid;
    w_gnt_d = bus.d_valid & (~bus.i_valid | ~r_last_src);
    w_gnt_i = bus.i_valid & ~w_gnt_d;
    w_acc   = w_idle & (w_gnt_i | w_gnt_d);
    w_cmd   = w_gnt_d ? bus.d_cmd  : bus.i_cmd;
    w_addr  = w_gnt_d ? bus.d_addr : bus.i_addr;
    w_fwd   = w_acc & (w_cmd != 2'b00);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fwd) w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.m_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 8'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_src  <= 1'b1;
      r_m_addr    <= '0;
      r_m_cmd     <= 2'b00;
      r_m_src     <= 1'b0;
      r_cnt       <= 8'd0;
      r_grants_i  <= 32'd0;
      r_grants_d  <= 32'd0;
      r_conflicts <= 32'd0;
    end else begin
      if (w_fwd) begin
        r_m_addr   <= w_addr;
        r_m_cmd    <= w_cmd;
        r_m_src    <= w_gnt_d;
        r_last_src <= w_gnt_d;
        if (w_gnt_d) r_grants_d <= r_grants_d + 32'd1;
        else         r_grants_i <= r_grants_i + 32'd1;
      end
      if (w_idle && w_both) r_conflicts <= r_conflicts + 32'd1;
      if (r_state == S_ISSUE && bus.m_ready) r_cnt <= LAT_V;
      else if (r_state == S_WAIT)            r_cnt <= r_cnt - 8'd1;
    end
  end

  assign bus.i_ready   = w_idle & w_gnt_i;
  assign bus.d_ready   = w_idle & w_gnt_d;
  assign bus.m_valid   = (r_state == S_ISSUE);
  assign bus.m_addr    = r_m_addr;
  assign bus.m_cmd     = r_m_cmd;
  assign bus.m_src     = r_m_src;
  assign bus.done      = (r_state == S_WAIT) && (r_cnt == 8'd1);
  assign bus.grants_i  = r_grants_i;
  assign bus.grants_d  = r_grants_d;
  assign bus.conflicts = r_conflicts;
endmodule

// File: tb/tb_nl_req_arbiter.sv
// Directed bench for nl_req_arbiter (LAT=4): inputs change 1ns after posedge, outputs sampled on negedge.
module tb_nl_req_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  nl_req_arbiter_if #(.ADDR_W(26)) bus ();

  nl_req_arbiter #(.ADDR_W(26), .LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_cmd = 2'b00;
    bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_cmd = 2'b00;
    bus.m_ready = 1'b0;

    // reset state
    smp();
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_cmd", bus.m_cmd, 0);
    check("rst_m_src", bus.m_src, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", {bus.i_ready, bus.d_ready}, 0);
    check("rst_counters", {bus.grants_i, bus.grants_d} | bus.conflicts, 0);

    // single I-cache read
    cyc();
    rst = 1'b0;
    bus.i_valid = 1'b1; bus.i_addr = 26'h0ABCDEF; bus.i_cmd = 2'b01; bus.m_ready = 1'b1;
    smp();
    check("t1_i_ready", bus.i_ready, 1);
    check("t1_d_ready", bus.d_ready, 0);
    cyc();
    bus.i_valid = 1'b0;
    smp();
    check("t1_m_valid", bus.m_valid, 1);
    check("t1_m_addr", bus.m_addr, 26'h0ABCDEF);
    check("t1_m_src", bus.m_src, 0);
    check("t1_m_cmd", bus.m_cmd, 2'b01);
    for (int k = 2; k <= 5; k++) begin
      cyc();
      smp();
      check($sformatf("t1_done_c%0d", k), bus.done, (k == 5) ? 1 : 0);
      if (k == 2) check("t1_m_valid_wait", bus.m_valid, 0);
    end
    cyc();
    smp();
    check("t1_done_c6", bus.done, 0);
    check("t1_grants_i", bus.grants_i, 1);

    // both valid continuously: strict I,D,I,D
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    bus.i_valid = 1'b1; bus.i_addr = 26'h0000100; bus.i_cmd = 2'b01;
    bus.d_valid = 1'b1; bus.d_addr = 26'h0000200; bus.d_cmd = 2'b01;
    for (int k = 0; k < 4; k++) begin
      smp();
      check($sformatf("t2_i_ready_%0d", k), bus.i_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("t2_d_ready_%0d", k), bus.d_ready, (k % 2 == 1) ? 1 : 0);
      cyc();
      if (k == 3) begin
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
      end
      smp();
      check($sformatf("t2_m_src_%0d", k), bus.m_src, (k % 2 == 1) ? 1 : 0);
      check($sformatf("t2_m_addr_%0d", k), bus.m_addr, (k % 2 == 1) ? 26'h0000200 : 26'h0000100);
      repeat (5) cyc();
    end
    smp();
    check("t2_grants_i", bus.grants_i, 2);
    check("t2_grants_d", bus.grants_d, 2);
    check("t2_conflicts", bus.conflicts, 4);

    // D write with m_ready stalled 3 cycles
    cyc();
    bus.d_valid = 1'b1; bus.d_cmd = 2'b10; bus.d_addr = 26'h3C0FFEE; bus.m_ready = 1'b0;
    smp();
    check("t3_d_ready", bus.d_ready, 1);
    check("t3_i_ready", bus.i_ready, 0);
    cyc();
    bus.d_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (j == 4) bus.m_ready = 1'b1;
      smp();
      check($sformatf("t3_m_valid_%0d", j), bus.m_valid, 1);
      check($sformatf("t3_m_addr_%0d", j), bus.m_addr, 26'h3C0FFEE);
      check($sformatf("t3_m_cmd_%0d", j), bus.m_cmd, 2'b10);
      if (j < 4) cyc();
    end
    for (int j = 5; j <= 8; j++) begin
      cyc();
      smp();
      check($sformatf("t3_done_%0d", j), bus.done, (j == 8) ? 1 : 0);
      if (j == 5) check("t3_m_valid_drop", bus.m_valid, 0);
    end
    cyc();

    // reset during WAIT
    bus.i_valid = 1'b1; bus.i_addr = 26'h0000123; bus.i_cmd = 2'b01;
    smp();
    check("t4_i_ready", bus.i_ready, 1);
    cyc();
    bus.i_valid = 1'b0;
    smp();
    check("t4_m_valid", bus.m_valid, 1);
    cyc();
    smp();
    check("t4_in_wait", bus.m_valid, 0);
    cyc();
    rst = 1'b1;
    #1;
    check("t4_rst_m_valid", bus.m_valid, 0);
    check("t4_rst_done", bus.done, 0);
    check("t4_rst_grants_i", bus.grants_i, 0);
    check("t4_rst_grants_d", bus.grants_d, 0);
    check("t4_rst_conflicts", bus.conflicts, 0);
    check("t4_rst_m_addr", bus.m_addr, 0);
    cyc();
    smp();
    check("t4_no_done", bus.done, 0);
    cyc();
    rst = 1'b0;
    bus.i_valid = 1'b1; bus.i_addr = 26'h2345678;
    smp();
    check("t4_post_i_ready", bus.i_ready, 1);
    check("t4_post_done", bus.done, 0);
    cyc();
    bus.i_valid = 1'b0;
    smp();
    check("t4_post_m_valid", bus.m_valid, 1);
    check("t4_post_m_addr", bus.m_addr, 26'h2345678);
    repeat (5) cyc();

    // cmd 00 from D: accepted, dropped, tie still to I
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    bus.d_valid = 1'b1; bus.d_cmd = 2'b00; bus.d_addr = 26'h0001111;
    smp();
    check("t5_d_ready", bus.d_ready, 1);
    check("t5_i_ready", bus.i_ready, 0);
    cyc();
    bus.d_valid = 1'b0;
    smp();
    check("t5_m_valid", bus.m_valid, 0);
    check("t5_grants_d", bus.grants_d, 0);
    check("t5_d_ready_off", bus.d_ready, 0);
    cyc();
    bus.i_valid = 1'b1; bus.i_cmd = 2'b01; bus.i_addr = 26'h0000456;
    bus.d_valid = 1'b1; bus.d_cmd = 2'b01;
    smp();
    check("t5_tie_i_ready", bus.i_ready, 1);
    check("t5_tie_d_ready", bus.d_ready, 0);
    cyc();
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    smp();
    check("t5_m_src", bus.m_src, 0);
    check("t5_grants_i", bus.grants_i, 1);
    repeat (5) cyc();

    // grants_d wrap
    force dut.r_grants_d = 32'hFFFFFFFF;
    #1;
    release dut.r_grants_d;
    smp();
    check("t6_preload", bus.grants_d, 32'hFFFFFFFF);
    cyc();
    bus.d_valid = 1'b1; bus.d_cmd = 2'b01; bus.d_addr = 26'h00000FF;
    smp();
    check("t6_d_ready", bus.d_ready, 1);
    cyc();
    bus.d_valid = 1'b0;
    smp();
    check("t6_grants_d_wrap", bus.grants_d, 0);
    check("t6_m_src", bus.m_src, 1);
    repeat (6) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
